memory_bank: RTL and testbench

//  Parametrised single-write, dual-read RAM; successor to the CPU data/program memory.

---
 rtl/memory_bank.sv | 124 ++++++++++++
 tb/tb_memory_bank.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/memory_bank.sv
// Single-write, dual-read RAM. Port A reads combinationally; port B reads through a register.
// After reset a clear sequencer writes INIT_VAL to every address before the memory is usable.
module memory_bank #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic              rd_b_en,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              busy,
  output logic              wr_err
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W:0]   clr_ptr_r;
  logic [ADDR_W:0]   clr_ptr_s;
  logic              busy_r;
  logic              busy_s;
  logic              wr_err_r;
  logic              wr_err_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_din_s;
  logic [DATA_W-1:0] rd_b_r;

  // State, clear pointer and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= CLEAR;
      clr_ptr_r <= {(ADDR_W + 1){1'b0}};
      busy_r    <= 1'b1;
      wr_err_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      clr_ptr_r <= clr_ptr_s;
      busy_r    <= busy_s;
      wr_err_r  <= wr_err_s;
    end
  end

  // Next-state logic; also selects between sequencer and user as the array writer.
  always_comb begin
    state_s    = state_r;
    clr_ptr_s  = clr_ptr_r;
    busy_s     = busy_r;
    wr_err_s   = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = wr_addr;
    mem_din_s  = wr_data;
    case (state_r)
      CLEAR: begin
        mem_we_s   = 1'b1;
        mem_addr_s = clr_ptr_r[ADDR_W-1:0];
        mem_din_s  = INIT_VAL;
        clr_ptr_s  = clr_ptr_r + PTR_ONE;
        wr_err_s   = we;
        if (clr_ptr_r == LAST_PTR) begin
          state_s = READY;
          busy_s  = 1'b0;
        end else begin
          state_s = CLEAR;
          busy_s  = 1'b1;
        end
      end
      READY: begin
        mem_we_s = we;
        busy_s   = 1'b0;
      end
      default: begin
        state_s   = CLEAR;
        clr_ptr_s = {(ADDR_W + 1){1'b0}};
        busy_s    = 1'b1;
      end
    endcase
  end

  // Array write port; nothing is written while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      mem[mem_addr_s] <= mem_din_s;
    end
  end

  // Port B registered read with write-first bypass on a same-address write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_b_r <= {DATA_W{1'b0}};
    end else if (rd_b_en) begin
      if (busy_r) begin
        rd_b_r <= INIT_VAL;
      end else if (we && (wr_addr == rd_b_addr)) begin
        rd_b_r <= wr_data;
      end else begin
        rd_b_r <= mem[rd_b_addr];
      end
    end
  end

  assign rd_a_data = busy_r ? INIT_VAL : mem[rd_a_addr];
  assign rd_b_data = rd_b_r;
  assign busy      = busy_r;
  assign wr_err    = wr_err_r;

endmodule

// File: tb/tb_memory_bank.sv
// Directed bench for memory_bank (DATA_W=8, ADDR_W=4, INIT_VAL=8'hA5): a vector table for
// READY-mode reads/writes plus hand-written sequences for clear timing, dropped writes and re-reset.
module tb_memory_bank;

  logic       clk;
  logic       rst;
  logic       we;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_a_addr;
  logic [7:0] rd_a_data;
  logic       rd_b_en;
  logic [3:0] rd_b_addr;
  logic [7:0] rd_b_data;
  logic       busy;
  logic       wr_err;

  int checks;
  int errors;

  memory_bank #(
    .DATA_W  (8),
    .ADDR_W  (4),
    .INIT_VAL(8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_a_addr(rd_a_addr),
    .rd_a_data(rd_a_data),
    .rd_b_en  (rd_b_en),
    .rd_b_addr(rd_b_addr),
    .rd_b_data(rd_b_data),
    .busy     (busy),
    .wr_err   (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] rd_a_addr;
    logic       rd_b_en;
    logic [3:0] rd_b_addr;
    logic [7:0] exp_a_pre;
    logic [7:0] exp_a_post;
    logic [7:0] exp_b;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    we = 1'b0; wr_addr = 4'h0; wr_data = 8'h00;
    rd_a_addr = 4'h0; rd_b_en = 1'b0; rd_b_addr = 4'h0;

    //             we    wa     wd     ra     ben   rb     a_pre  a_post b
    vecs[0]  = '{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 4'h0, 8'hA5, 8'hA5, 8'hA5};
    vecs[1]  = '{1'b1, 4'hF, 8'h93, 4'hF, 1'b0, 4'h0, 8'hA5, 8'h93, 8'hA5};
    vecs[2]  = '{1'b0, 4'h0, 8'h00, 4'hF, 1'b1, 4'hF, 8'h93, 8'h93, 8'h93};
    vecs[3]  = '{1'b1, 4'h5, 8'h3C, 4'h5, 1'b1, 4'h5, 8'hA5, 8'h3C, 8'h3C};
    vecs[4]  = '{1'b1, 4'h7, 8'h11, 4'h0, 1'b1, 4'h5, 8'hA5, 8'hA5, 8'h3C};
    vecs[5]  = '{1'b1, 4'h0, 8'h22, 4'h7, 1'b1, 4'h7, 8'h11, 8'h11, 8'h11};
    vecs[6]  = '{1'b1, 4'h7, 8'h44, 4'h7, 1'b0, 4'h7, 8'h11, 8'h44, 8'h11};
    vecs[7]  = '{1'b1, 4'h9, 8'h55, 4'h0, 1'b0, 4'h9, 8'h22, 8'h22, 8'h11};
    vecs[8]  = '{1'b0, 4'h0, 8'h00, 4'h9, 1'b0, 4'h0, 8'h55, 8'h55, 8'h11};
    vecs[9]  = '{1'b1, 4'hF, 8'h66, 4'hF, 1'b0, 4'hF, 8'h93, 8'h66, 8'h11};
    vecs[10] = '{1'b0, 4'h0, 8'h00, 4'h3, 1'b1, 4'h7, 8'hA5, 8'hA5, 8'h44};
    vecs[11] = '{1'b0, 4'h0, 8'h00, 4'hF, 1'b1, 4'hF, 8'h66, 8'h66, 8'h66};
    vecs[12] = '{1'b1, 4'h8, 8'h77, 4'h8, 1'b1, 4'h9, 8'hA5, 8'h77, 8'h55};

    // Reset state and full clear timing.
    do_reset();
    chk("reset_busy", {7'h00, busy}, 8'h01);
    chk("reset_rd_b", rd_b_data, 8'h00);
    chk("reset_wr_err", {7'h00, wr_err}, 8'h00);
    chk("reset_rd_a_forced", rd_a_data, 8'hA5);
    wait_ready(n);
    chk("clear_cycles", 8'(n), 8'd16);
    for (int i = 0; i < 16; i++) begin
      rd_a_addr = 4'(i);
      #1;
      chk($sformatf("cleared_word_%0d", i), rd_a_data, 8'hA5);
    end

    // READY-mode vector table.
    for (int i = 0; i < 13; i++) begin
      we        = vecs[i].we;
      wr_addr   = vecs[i].wr_addr;
      wr_data   = vecs[i].wr_data;
      rd_a_addr = vecs[i].rd_a_addr;
      rd_b_en   = vecs[i].rd_b_en;
      rd_b_addr = vecs[i].rd_b_addr;
      #1;
      chk($sformatf("vec%0d_rd_a_pre", i), rd_a_data, vecs[i].exp_a_pre);
      step();
      chk($sformatf("vec%0d_rd_a_post", i), rd_a_data, vecs[i].exp_a_post);
      chk($sformatf("vec%0d_rd_b", i), rd_b_data, vecs[i].exp_b);
      chk($sformatf("vec%0d_wr_err", i), {7'h00, wr_err}, 8'h00);
    end
    we = 1'b0; rd_b_en = 1'b0;

    // Write during CLEAR is dropped and flagged for one cycle; reads forced to INIT_VAL.
    do_reset();
    rd_a_addr = 4'hF;
    rd_b_en = 1'b1; rd_b_addr = 4'hF;
    step();
    step();
    chk("busy_read_a", rd_a_data, 8'hA5);
    chk("busy_read_b", rd_b_data, 8'hA5);
    we = 1'b1; wr_addr = 4'h9; wr_data = 8'h12;
    step();
    we = 1'b0;
    chk("drop_wr_err_pulse", {7'h00, wr_err}, 8'h01);
    step();
    chk("drop_wr_err_clear", {7'h00, wr_err}, 8'h00);
    wait_ready(n);
    chk("drop_clear_cycles", 8'(n + 4), 8'd16);
    rd_a_addr = 4'h9;
    #1;
    chk("drop_addr_init", rd_a_data, 8'hA5);

    // Reset in the middle of a clear restarts the full sequence.
    rd_b_en = 1'b0;
    do_reset();
    repeat (7) step();
    chk("midclear_busy", {7'h00, busy}, 8'h01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready(n);
    chk("restart_clear_cycles", 8'(n), 8'd16);
    rd_a_addr = 4'h0;
    #1;
    chk("restart_addr0", rd_a_data, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
